// File: rtl/uart_loader_pkg.sv
// Shared types for the UART frame loader: FSM state encoding and error codes.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      PAYLOAD,
      CHECK
   } loader_state_t;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_LEN = 2'b01;
   localparam err_code_t ERR_CHK = 2'b10;
   localparam err_code_t ERR_TMO = 2'b11;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES-1.
module idle_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic en_in,
   input  logic clr_in,
   output logic expired_out
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_in || !en_in) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The consumer leaves the enabled state on expiry, so this is a single-cycle pulse.
   assign expired_out = en_in && (cnt_q == CntLast);

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SOF/LEN_HI/LEN_LO/payload/XOR-checksum uploads from the UART and writes
// the payload into BRAM port B, reporting completion or a coded error.
module uart_frame_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned DEPTH          = 40_000,
   parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  data_valid_in,
   input  logic [7:0]            data_byte_in,
   output logic                  wr_en_out,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output logic [7:0]            wr_data_out,
   output logic                  busy_out,
   output logic                  frame_done_out,
   output logic                  frame_err_out,
   output logic [1:0]            err_code_out,
   output logic [15:0]           frame_len_out
);

   loader_state_t         state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            chk_q, chk_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   err_code_t             err_code_q, err_code_d;
   logic [15:0]           frame_len_q, frame_len_d;

   logic                  tmo_expired;
   logic [15:0]           len_rx;
   logic [15:0]           addr_next16;

   idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .en_in      (state_q != IDLE),
      .clr_in     (data_valid_in),
      .expired_out(tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      addr_d      = addr_q;
      chk_d       = chk_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      frame_len_d = frame_len_q;
      len_rx      = {len_q[15:8], data_byte_in};
      addr_next16 = 16'(addr_q) + 16'd1;

      unique case (state_q)
         IDLE: begin
            if (data_valid_in && (data_byte_in == SOF_BYTE)) begin
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (data_valid_in) begin
               len_d   = {data_byte_in, len_q[7:0]};
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (data_valid_in) begin
               len_d = len_rx;
               if ((len_rx == 16'd0) || ({16'd0, len_rx} > DEPTH)) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
                  state_d    = IDLE;
               end else begin
                  addr_d  = '0;
                  chk_d   = '0;
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (data_valid_in) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = data_byte_in;
               chk_d     = chk_q ^ data_byte_in;
               addr_d    = addr_q + ADDR_WIDTH'(1);
               if (addr_next16 == len_q) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (data_valid_in) begin
               if (data_byte_in == chk_q) begin
                  done_d      = 1'b1;
                  frame_len_d = len_q;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CHK;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A byte landing on the expiry cycle takes priority over the timeout.
      if (tmo_expired && !data_valid_in) begin
         err_d      = 1'b1;
         err_code_d = ERR_TMO;
         state_d    = IDLE;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         len_q       <= '0;
         addr_q      <= '0;
         chk_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         frame_len_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         chk_q       <= chk_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         frame_len_q <= frame_len_d;
      end
   end

   assign wr_en_out      = wr_en_q;
   assign wr_addr_out    = wr_addr_q;
   assign wr_data_out    = wr_data_q;
   assign busy_out       = busy_q;
   assign frame_done_out = done_q;
   assign frame_err_out  = err_q;
   assign err_code_out   = err_code_q;
   assign frame_len_out  = frame_len_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: directed frames push expected writes and
// done/err events; a negedge monitor pops and compares whatever the DUT emits.
module tb_uart_frame_loader;

   localparam int unsigned T     = 32;
   localparam int unsigned DEPTH = 40_000;
   localparam int unsigned AW    = 16;

   localparam int KWr   = 0;
   localparam int KDone = 1;
   localparam int KErr  = 2;

   typedef struct {
      int kind;
      int addr;
      int data;
      int code;
      int len;
      int cyc;
   } exp_t;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          data_valid_in = 1'b0;
   logic [7:0]    data_byte_in = 8'h00;
   logic          wr_en_out;
   logic [AW-1:0] wr_addr_out;
   logic [7:0]    wr_data_out;
   logic          busy_out;
   logic          frame_done_out;
   logic          frame_err_out;
   logic [1:0]    err_code_out;
   logic [15:0]   frame_len_out;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   busy_pending = 1'b0;

   uart_frame_loader #(
      .DEPTH         (DEPTH),
      .ADDR_WIDTH    (AW),
      .SOF_BYTE      (8'hA5),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .data_valid_in (data_valid_in),
      .data_byte_in  (data_byte_in),
      .wr_en_out     (wr_en_out),
      .wr_addr_out   (wr_addr_out),
      .wr_data_out   (wr_data_out),
      .busy_out      (busy_out),
      .frame_done_out(frame_done_out),
      .frame_err_out (frame_err_out),
      .err_code_out  (err_code_out),
      .frame_len_out (frame_len_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected DUT event with empty scoreboard (cycle %0d)", name, cyc);
   endtask

   task automatic push(input int kind, input int addr, input int data, input int code,
                       input int len, input int c);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.len = len; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic push_wr(input int addr, input int data);
      push(KWr, addr, data, 0, 0, -1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_in);
      data_valid_in = 1'b1;
      data_byte_in  = b;
      @(negedge clk_in);
      data_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Monitor: pops one expected item per DUT event.
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         exp_t e;
         if (busy_pending) begin
            check("busy_after_pulse", {31'd0, busy_out}, 32'd0);
            busy_pending = 1'b0;
         end
         if (frame_done_out || frame_err_out) begin
            check("done_err_exclusive", {31'd0, frame_done_out & frame_err_out}, 32'd0);
         end
         if (wr_en_out) begin
            if (sb.size() == 0) fail_event("write");
            else begin
               e = sb.pop_front();
               check("write_kind", KWr, e.kind);
               check("write_addr", {16'd0, wr_addr_out}, e.addr);
               check("write_data", {24'd0, wr_data_out}, e.data);
            end
         end
         if (frame_done_out) begin
            if (sb.size() == 0) fail_event("done");
            else begin
               e = sb.pop_front();
               check("done_kind", KDone, e.kind);
               check("done_frame_len", {16'd0, frame_len_out}, e.len);
               busy_pending = 1'b1;
            end
         end
         if (frame_err_out) begin
            if (sb.size() == 0) fail_event("err");
            else begin
               e = sb.pop_front();
               check("err_kind", KErr, e.kind);
               check("err_code", {30'd0, err_code_out}, e.code);
               check("err_frame_len_kept", {16'd0, frame_len_out}, e.len);
               if (e.cyc >= 0) check("err_timeout_cycle", cyc, e.cyc);
               busy_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      int c0;
      bit drained;

      // Reset state
      idle(3);
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      idle(2);
      check("rst_wr_en", {31'd0, wr_en_out}, 32'd0);
      check("rst_wr_addr", {16'd0, wr_addr_out}, 32'd0);
      check("rst_err_code", {30'd0, err_code_out}, 32'd0);
      check("rst_frame_len", {16'd0, frame_len_out}, 32'd0);

      // 1: good frame, checksum 11^22^44 = 77
      push_wr(0, 'h11); push_wr(1, 'h22); push_wr(2, 'h44);
      push(KDone, 0, 0, 0, 3, -1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h44); send_byte(8'h77);

      // 2: bad checksum
      push_wr(0, 'h11); push_wr(1, 'h22); push_wr(2, 'h44);
      push(KErr, 0, 0, 2, 3, -1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h44); send_byte(8'h76);

      // 3: N = 0 and N = 40001 rejected
      push(KErr, 0, 0, 1, 3, -1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      push(KErr, 0, 0, 1, 3, -1);
      send_byte(8'hA5); send_byte(8'h9C); send_byte(8'h41);

      // 4a: silence after first payload byte times out
      push_wr(0, 'h01);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04); send_byte(8'h01);
      c0 = cyc;
      push(KErr, 0, 0, 3, 3, c0 + T);
      idle(T + 4);

      // 4b: bytes landing exactly on the expiry cycle keep the frame alive
      push_wr(0, 'h10); push_wr(1, 'h20);
      push(KDone, 0, 0, 0, 2, -1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h10);
      idle(T - 2);
      send_byte(8'h20);
      idle(T - 2);
      send_byte(8'h30);
      idle(3);

      // 5: async reset mid-payload
      push_wr(0, 'hC3); push_wr(1, 'h3C);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'hC3); send_byte(8'h3C);
      idle(1);
      #2 rst_n_in = 1'b0;
      #1;
      check("amid_busy", {31'd0, busy_out}, 32'd0);
      check("amid_wr_addr", {16'd0, wr_addr_out}, 32'd0);
      check("amid_wr_data", {24'd0, wr_data_out}, 32'd0);
      check("amid_frame_len", {16'd0, frame_len_out}, 32'd0);
      check("amid_err_code", {30'd0, err_code_out}, 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      push_wr(0, 'h5A);
      push(KDone, 0, 0, 0, 1, -1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h5A); send_byte(8'h5A);

      // 6: garbage before SOF, then back-to-back frames with 1-cycle gaps
      push_wr(0, 'h01); push_wr(1, 'h02);
      push(KDone, 0, 0, 0, 2, -1);
      push_wr(0, 'hFF);
      push(KDone, 0, 0, 0, 1, -1);
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA4);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hFF); send_byte(8'hFF);

      drained = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_in);
         if (sb.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      idle(2);
      check("scoreboard_drained", sb.size(), 32'd0);
      if (!drained) $display("FAIL drain_timeout: %0d items left, expected 0", sb.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
